// File: rtl/bday_link_pkg.sv
// Shared definitions for the birthday sequence-detect link (TX serializer and RX detector).
package bday_link_pkg;

  localparam int             BDAY_PAT_W   = 9;
  localparam logic [8:0]     BDAY_PATTERN = 9'b100000101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } bday_state_e;

endpackage

// File: rtl/bday_sync2.sv
// Two-flop synchroniser with async active-low reset; resets to 0.
module bday_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bday_pattern_serializer.sv
// Serial frame transmitter: repeats PATTERN MSB-first plus idle gap while enabled,
// inverting the LSB of every DECOY_EVERY-th frame, and counts genuine/decoy frames.
module bday_pattern_serializer
  import bday_link_pkg::*;
#(
  parameter int             PAT_W       = BDAY_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN   = BDAY_PATTERN,
  parameter int             GAP_BITS    = 4,
  parameter int             DECOY_EVERY = 3,
  parameter int             CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tx_en_n,
  output logic             o_serial_data,
  output logic             o_tx_busy,
  output logic             o_frame_strobe,
  output logic [CNT_W-1:0] o_frame_count,
  output logic [CNT_W-1:0] o_decoy_count
);

  localparam int BW   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam int GW   = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam int PH_W = (DECOY_EVERY > 1) ? $clog2(DECOY_EVERY) : 1;

  localparam logic [BW-1:0]   BIT_LAST  = BW'(PAT_W - 1);
  localparam logic [GW-1:0]   GAP_LAST  = (GAP_BITS > 0) ? GW'(GAP_BITS - 1) : '0;
  localparam logic [PH_W-1:0] PH_LAST   = (DECOY_EVERY > 0) ? PH_W'(DECOY_EVERY - 1) : '0;

  logic              en_s;
  bday_state_e       state_q, state_n;
  logic              start_frame, frame_end;
  logic [PAT_W-1:0]  shreg;
  logic [BW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;
  logic [PH_W-1:0]   phase_q, phase_n;
  logic              decoy_q, next_decoy;
  logic [PAT_W-1:0]  load_pat;

  bday_sync2 u_en_sync (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .d     (~i_tx_en_n),
    .q     (en_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_n;
  end

  // A finished frame always runs to the end of its gap before en_s is looked at again.
  always_comb begin
    state_n     = state_q;
    start_frame = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_s) begin
          state_n     = ST_SHIFT;
          start_frame = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt == '0) begin
          frame_end = 1'b1;
          if (GAP_BITS > 0)  state_n = ST_GAP;
          else if (en_s)     start_frame = 1'b1;
          else               state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        if (gap_cnt == '0) begin
          if (en_s) begin
            state_n     = ST_SHIFT;
            start_frame = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // phase tracks the 1-based frame index modulo DECOY_EVERY; it survives deassert.
  always_comb begin
    phase_n    = phase_q;
    next_decoy = 1'b0;
    if (DECOY_EVERY > 0) begin
      phase_n    = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
      next_decoy = (phase_n == '0);
    end
    load_pat = next_decoy ? (PATTERN ^ PAT_W'(1)) : PATTERN;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_serial_data <= 1'b0;
      shreg         <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      phase_q       <= '0;
      decoy_q       <= 1'b0;
    end else if (start_frame) begin
      o_serial_data <= load_pat[PAT_W-1];
      shreg         <= load_pat << 1;
      bit_cnt       <= BIT_LAST;
      phase_q       <= phase_n;
      decoy_q       <= next_decoy;
    end else if (state_q == ST_SHIFT) begin
      if (frame_end) begin
        o_serial_data <= 1'b0;
        gap_cnt       <= GAP_LAST;
      end else begin
        o_serial_data <= shreg[PAT_W-1];
        shreg         <= shreg << 1;
        bit_cnt       <= bit_cnt - BW'(1);
      end
    end else if (state_q == ST_GAP) begin
      gap_cnt <= gap_cnt - GW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_count <= '0;
      o_decoy_count <= '0;
    end else if (frame_end) begin
      if (decoy_q) begin
        if (o_decoy_count != '1) o_decoy_count <= o_decoy_count + CNT_W'(1);
      end else begin
        if (o_frame_count != '1) o_frame_count <= o_frame_count + CNT_W'(1);
      end
    end
  end

  assign o_tx_busy      = (state_q != ST_IDLE);
  assign o_frame_strobe = frame_end;

endmodule

// File: tb/tb_bday_pattern_serializer.sv
// Self-checking bench: predicts the serial line cycle by cycle from the frame/gap/decoy rules.
module tb_bday_pattern_serializer;

  localparam int PW  = 9;
  localparam int GAP = 4;
  localparam int DEC = 3;
  localparam int PER = PW + GAP;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_en_n;
  logic        sat_en_n;
  logic        serial, busy, strobe;
  logic [15:0] fcnt, dcnt;
  logic        s_serial, s_busy, s_strobe;
  logic [3:0]  s_fcnt, s_dcnt;

  int n_checks    = 0;
  int n_fail      = 0;
  int frames_sent = 0;
  int exp_genuine = 0;
  int exp_decoy   = 0;

  always #5 clk = ~clk;

  bday_pattern_serializer dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_tx_en_n      (tx_en_n),
    .o_serial_data  (serial),
    .o_tx_busy      (busy),
    .o_frame_strobe (strobe),
    .o_frame_count  (fcnt),
    .o_decoy_count  (dcnt)
  );

  bday_pattern_serializer #(
    .GAP_BITS    (0),
    .DECOY_EVERY (0),
    .CNT_W       (4)
  ) dut_sat (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_tx_en_n      (sat_en_n),
    .o_serial_data  (s_serial),
    .o_tx_busy      (s_busy),
    .o_frame_strobe (s_strobe),
    .o_frame_count  (s_fcnt),
    .o_decoy_count  (s_dcnt)
  );

  // Bit j (0 = first on the line) of 1-based frame 'frame', gap bits included.
  function automatic logic model_bit(int frame, int j, int decoy_every);
    logic [PW-1:0] p;
    p = 9'b100000101;
    if (decoy_every != 0 && (frame % decoy_every) == 0) p[0] = ~p[0];
    if (j >= PW) return 1'b0;
    return p[PW-1-j];
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Enable held low for 'len' cycles; first bit appears 3 edges after it is driven low.
  task automatic apply_burst(input int len);
    int   n, total, j, f;
    logic in_win, exp_line, exp_strobe;
    n     = 1 + (len - 1) / PER;
    total = 3 + n * PER + 2;
    tx_en_n = 1'b0;
    for (int c = 1; c <= total; c++) begin
      @(posedge clk); #1;
      if (c == len) tx_en_n = 1'b1;
      in_win     = (c >= 3) && (c < 3 + n * PER);
      exp_line   = 1'b0;
      exp_strobe = 1'b0;
      if (in_win) begin
        j          = (c - 3) % PER;
        f          = frames_sent + (c - 3) / PER + 1;
        exp_line   = model_bit(f, j, DEC);
        exp_strobe = (j == PW - 1);
        if (exp_strobe) begin
          if (f % DEC == 0) exp_decoy++;
          else              exp_genuine++;
        end
      end
      check_output("line",   32'(serial), 32'(exp_line));
      check_output("busy",   32'(busy),   32'(in_win));
      check_output("strobe", 32'(strobe), 32'(exp_strobe));
    end
    frames_sent += n;
    check_output("frame_count", 32'(fcnt), 32'(exp_genuine));
    check_output("decoy_count", 32'(dcnt), 32'(exp_decoy));
  endtask

  initial begin
    int len;
    rst_n    = 1'b0;
    tx_en_n  = 1'b1;
    sat_en_n = 1'b1;
    #1;
    check_output("rst_line",   32'(serial), 32'd0);
    check_output("rst_busy",   32'(busy),   32'd0);
    check_output("rst_strobe", 32'(strobe), 32'd0);
    check_output("rst_fcnt",   32'(fcnt),   32'd0);
    check_output("rst_dcnt",   32'(dcnt),   32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] idle with enable inactive");
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      check_output("idle_line", 32'(serial), 32'd0);
      check_output("idle_busy", 32'(busy),   32'd0);
    end

    $display("[TB] single short pulse");
    apply_burst(3);

    // Clear the frame index so the five-frame burst starts from frame 1.
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    frames_sent = 0; exp_genuine = 0; exp_decoy = 0;
    check_output("rst2_fcnt", 32'(fcnt), 32'd0);

    $display("[TB] five back-to-back frames");
    apply_burst(60);
    check_output("five_fcnt", 32'(fcnt), 32'd4);
    check_output("five_dcnt", 32'(dcnt), 32'd1);

    $display("[TB] deassert mid frame 2");
    apply_burst(20);

    $display("[TB] random bursts");
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(2, 45));
      apply_burst(len);
      repeat (int'($urandom_range(0, 5))) @(posedge clk);
      #0;
    end

    $display("[TB] reset mid frame");
    tx_en_n = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(posedge clk); #1;
      if (c == 3) tx_en_n = 1'b1;
      if (c >= 3) check_output("pre_rst_line", 32'(serial), 32'(model_bit(frames_sent + 1, c - 3, DEC)));
    end
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_line",   32'(serial), 32'd0);
    check_output("mid_rst_busy",   32'(busy),   32'd0);
    check_output("mid_rst_strobe", 32'(strobe), 32'd0);
    check_output("mid_rst_fcnt",   32'(fcnt),   32'd0);
    check_output("mid_rst_dcnt",   32'(dcnt),   32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    frames_sent = 0; exp_genuine = 0; exp_decoy = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check_output("post_rst_line",   32'(serial), 32'd0);
      check_output("post_rst_strobe", 32'(strobe), 32'd0);
    end

    $display("[TB] saturation, no gap, no decoys");
    sat_en_n = 1'b0;
    for (int c = 1; c <= 3 + 20 * PW + 2; c++) begin
      @(posedge clk); #1;
      if (c == 172) sat_en_n = 1'b1;
      if (c >= 3 && c < 3 + 20 * PW) begin
        check_output("sat_line", 32'(s_serial), 32'(model_bit(1, (c - 3) % PW, 0)));
        check_output("sat_busy", 32'(s_busy),   32'd1);
      end else begin
        check_output("sat_idle_line", 32'(s_serial), 32'd0);
      end
    end
    check_output("sat_fcnt", 32'(s_fcnt), 32'd15);
    check_output("sat_dcnt", 32'(s_dcnt), 32'd0);
    check_output("sat_main_fcnt", 32'(fcnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
